// File: rtl/bank_sram_write_if_pkg.sv
// Shared configuration for the banked SRAM read/write interfaces.
// Also holds the rotate index helper that both sides' bank mapping relies on.
package bank_sram_write_if_pkg;

    localparam int unsigned XOR_BW_DEF = 4;
    localparam int unsigned ID_BW_DEF  = 2;

    // Source bit feeding destination bit j of an n-bit rotate-left by amt.
    function automatic int unsigned rot_src_idx(input int unsigned j,
                                                input int unsigned amt,
                                                input int unsigned n);
        return (j + n - (amt % n)) % n;
    endfunction

endpackage

// File: rtl/bank_sram_write_if_xor_map.sv
// Lane address to (bank, word) mapping: XOR swizzle then rotate.
// Shared with the read interface so the two mappings stay bit-identical.
module bank_xor_map
    import bank_sram_write_if_pkg::*;
#(
    parameter  int unsigned NBANK        = 16,
    parameter  int unsigned NDATA        = 32,
    parameter  int unsigned XOR_BW       = XOR_BW_DEF,
    localparam int unsigned CLOG2_NDATA  = $clog2(NDATA),
    localparam int unsigned CLOG2_NBANK  = $clog2(NBANK),
    localparam int unsigned ABW          = CLOG2_NDATA + CLOG2_NBANK,
    localparam int unsigned CCLOG2_NBANK = $clog2(CLOG2_NBANK + 1)
) (
    input  logic [ABW-1:0]                        waddr,
    input  logic [CLOG2_NBANK-1:0][XOR_BW-1:0]    xor_src,
    input  logic [CCLOG2_NBANK-1:0]               xor_swap,
    output logic [CLOG2_NBANK-1:0]                bank_c,
    output logic [CLOG2_NDATA-1:0]                word_c
);

    localparam int unsigned XOR_ADDR_BW = 1 << XOR_BW;
    localparam int unsigned IDXW        = (CLOG2_NBANK > 1) ? $clog2(CLOG2_NBANK) : 1;

    logic [XOR_ADDR_BW-1:0] ax;
    logic [CLOG2_NBANK-1:0] x;

    // MSB is excluded from the XOR sources so selectors can point at a known-zero bit.
    always_comb begin
        ax             = '0;
        x              = '0;
        bank_c         = '0;
        ax[ABW-2:0]    = waddr[ABW-2:0];
        for (int j = 0; j < int'(CLOG2_NBANK); j++) begin
            x[j] = waddr[j] ^ ax[xor_src[j]];
        end
        for (int j = 0; j < int'(CLOG2_NBANK); j++) begin
            bank_c[j] = x[IDXW'(rot_src_idx(j, 32'(xor_swap), CLOG2_NBANK))];
        end
    end

    assign word_c = waddr[ABW-1:CLOG2_NBANK];

endmodule

// File: rtl/bank_sram_write_if.sv
// Write side of the remap-cache banked SRAM: routes one row of lane writes to
// their banks through a single holdable register stage and reports landed slots.
module bank_sram_write_if
    import bank_sram_write_if_pkg::*;
#(
    parameter  int unsigned BW           = 8,
    parameter  int unsigned NDATA        = 32,
    parameter  int unsigned NBANK        = 16,
    parameter  int unsigned ID_BW        = ID_BW_DEF,
    parameter  int unsigned XOR_BW       = XOR_BW_DEF,
    localparam int unsigned CLOG2_NDATA  = $clog2(NDATA),
    localparam int unsigned CLOG2_NBANK  = $clog2(NBANK),
    localparam int unsigned ABW          = CLOG2_NDATA + CLOG2_NBANK,
    localparam int unsigned CCLOG2_NBANK = $clog2(CLOG2_NBANK + 1)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 wrin_rdy,
    output logic                                 wrin_ack,
    input  logic [CLOG2_NBANK-1:0][XOR_BW-1:0]   i_xor_src,
    input  logic [CCLOG2_NBANK-1:0]              i_xor_swap,
    input  logic [NBANK-1:0][ABW-1:0]            i_waddr,
    input  logic [NBANK-1:0][BW-1:0]             i_wdata,
    input  logic [NBANK-1:0]                     i_wmask,
    input  logic [ID_BW-1:0]                     i_id,
    input  logic                                 i_commit,
    input  logic                                 i_hold,
    output logic [NBANK-1:0]                     o_sram_we,
    output logic [NBANK-1:0][CLOG2_NDATA-1:0]    o_sram_waddr,
    output logic [NBANK-1:0][BW-1:0]             o_sram_wdata,
    output logic                                 filled_dval,
    output logic [ID_BW-1:0]                     o_filled_id,
    output logic                                 o_conflict
);

    logic [NBANK-1:0][CLOG2_NBANK-1:0] lane_bank;
    logic [NBANK-1:0][CLOG2_NDATA-1:0] lane_word;

    logic [NBANK-1:0]                  route_we;
    logic [NBANK-1:0][CLOG2_NDATA-1:0] route_word;
    logic [NBANK-1:0][BW-1:0]          route_data;
    logic                              conflict_c;

    logic                              s1_valid;
    logic [NBANK-1:0]                  s1_we;
    logic                              s1_commit;
    logic [ID_BW-1:0]                  s1_id;
    logic                              issue_c;

    for (genvar l = 0; l < NBANK; l++) begin : g_lane
        bank_xor_map #(
            .NBANK  (NBANK),
            .NDATA  (NDATA),
            .XOR_BW (XOR_BW)
        ) u_map (
            .waddr    (i_waddr[l]),
            .xor_src  (i_xor_src),
            .xor_swap (i_xor_swap),
            .bank_c   (lane_bank[l]),
            .word_c   (lane_word[l])
        );
    end

    // Per-bank priority select: the lowest-index masked lane wins, later hits flag a conflict.
    always_comb begin
        route_we   = '0;
        route_word = '0;
        route_data = '0;
        conflict_c = 1'b0;
        for (int b = 0; b < int'(NBANK); b++) begin
            for (int l = 0; l < int'(NBANK); l++) begin
                if (i_wmask[l] && (lane_bank[l] == CLOG2_NBANK'(b))) begin
                    if (route_we[b]) begin
                        conflict_c = 1'b1;
                    end else begin
                        route_we[b]   = 1'b1;
                        route_word[b] = lane_word[l];
                        route_data[b] = i_wdata[l];
                    end
                end
            end
        end
    end

    assign issue_c   = s1_valid && !i_hold;
    assign wrin_ack  = wrin_rdy && (!s1_valid || !i_hold);
    assign o_sram_we = issue_c ? s1_we : '0;

    // Control state; an empty-mask row still occupies S1 so its commit can land.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid    <= 1'b0;
            filled_dval <= 1'b0;
            o_filled_id <= '0;
            o_conflict  <= 1'b0;
        end else begin
            if (wrin_ack) begin
                s1_valid <= 1'b1;
            end else if (issue_c) begin
                s1_valid <= 1'b0;
            end
            filled_dval <= issue_c && s1_commit;
            if (issue_c && s1_commit) begin
                o_filled_id <= s1_id;
            end
            if (wrin_ack && conflict_c) begin
                o_conflict <= 1'b1;
            end
        end
    end

    // Row payload, loaded only on accept.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_we        <= '0;
            s1_commit    <= 1'b0;
            s1_id        <= '0;
            o_sram_waddr <= '0;
            o_sram_wdata <= '0;
        end else if (wrin_ack) begin
            s1_we        <= route_we;
            s1_commit    <= i_commit;
            s1_id        <= i_id;
            o_sram_waddr <= route_word;
            o_sram_wdata <= route_data;
        end
    end

endmodule

// File: doc/bank_sram_write_if.md
Name: bank_sram_write_if

Overview:
- Write-side companion of the remap-cache banked SRAM read interface.
- Accepts one row of NBANK lane writes (address, data, mask) per handshake and computes each lane's bank with the same XOR-swizzle and rotate mapping the read side uses.
- Routes lane data to the owning bank, drives one registered write per bank, and reports a freed or filled slot ID once the write has landed.
- Sits between the remap-cache fill path (DRAM return) and the NBANK single-port SRAM banks.

Parameters:
- BW, 8, data width per lane/bank.
- NDATA, 32, words per bank; CLOG2_NDATA = $clog2(NDATA).
- NBANK, 16, number of banks and lanes (power of 2); CLOG2_NBANK = $clog2(NBANK).
- ID_BW, 2, width of the slot ID.
- XOR_BW, TauCfg::XOR_BW, width of each XOR source-bit selector; XOR_ADDR_BW = 1<<XOR_BW.
- Derived: ABW = CLOG2_NDATA + CLOG2_NBANK; CCLOG2_NBANK = $clog2(CLOG2_NBANK+1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-low.
- wrin_rdy  in  1  write-row request valid.
- wrin_ack  out  1  write row accepted (combinational).
- i_xor_src  in  XOR_BW x CLOG2_NBANK  per bank-bit XOR source-bit index.
- i_xor_swap  in  CCLOG2_NBANK  bank-index rotate amount.
- i_waddr  in  ABW x NBANK  per-lane linear address.
- i_wdata  in  BW x NBANK  per-lane data.
- i_wmask  in  NBANK  lane enable; 0 means the lane is ignored.
- i_id  in  ID_BW  slot ID of this row.
- i_commit  in  1  last row of the slot.
- i_hold  in  1  SRAM ports borrowed by the read side this cycle.
- o_sram_we  out  NBANK  per-bank write enable.
- o_sram_waddr  out  CLOG2_NDATA x NBANK  per-bank word address.
- o_sram_wdata  out  BW x NBANK  per-bank write data.
- filled_dval  out  1  a committed slot has landed.
- o_filled_id  out  ID_BW  ID of the slot that landed.
- o_conflict  out  1  sticky bank-conflict error flag.

Behaviour:
- Bank mapping, per lane l, combinational:
  - ax = i_waddr[l] with its MSB cleared, zero-extended to XOR_ADDR_BW bits.
  - For each bit j: x[j] = i_waddr[l][j] ^ ax[i_xor_src[j]].
  - bank(l) = x rotated left by i_xor_swap, over CLOG2_NBANK bits.
  - word(l) = i_waddr[l][ABW-1:CLOG2_NBANK].
  - This mapping is bit-identical to the read interface's mapping.
- Routing:
  - Bank b takes the word and data of the lowest-index lane l with i_wmask[l]=1 and bank(l)=b.
  - If no such lane exists, bank b is not written.
- Pipeline: stage S1 is a register holding we, waddr, wdata, commit, id and a valid bit.
- Handshake and hold:
  - wrin_ack = wrin_rdy && (!s1_valid || !i_hold).
  - o_sram_we = s1_valid && !i_hold ? s1_we : 0.
  - On ack, S1 loads the new row; otherwise, if S1 is issuing, s1_valid clears.
  - While i_hold=1, S1 keeps all of its contents.
- Latency with no hold: ack in cycle T gives o_sram_we in cycle T+1, and filled_dval in cycle T+2 if i_commit was set.
  - filled_dval is a registered pulse, asserted one cycle after the issue of a row with commit=1.
  - o_filled_id updates only on that pulse and holds its value otherwise.
- Every accepted row occupies S1 for at least one cycle, including a row with an all-zero mask (needed so a commit still produces filled_dval).
- Back-to-back rows are accepted at one per cycle when i_hold=0.
- Simultaneous i_hold=1 with s1_valid=0: a new row is accepted into S1 and issues after the hold drops.
- Conflict: two or more masked-in lanes in the same row mapping to the same bank sets o_conflict; it stays set until reset. The lowest-index lane's write still happens.
- Reset (async, i_rst=0):
  - s1_valid=0, o_sram_we=0, o_sram_waddr=0, o_sram_wdata=0.
  - filled_dval=0, o_filled_id=0, o_conflict=0.
  - A row in flight during reset is dropped and produces no filled pulse.
- Data and address registers are clock-gated on ack.

Decomposition:
- Package TauCfg: XOR_BW and ID_BW defaults.
- Local constants: CLOG2_NBANK, ABW, CCLOG2_NBANK.
- Sub-module bank_xor_map: lane address → (bank, word), purely combinational. Shared with the read interface so the two mappings cannot drift.
- Routing is a priority one-hot select per bank. A butterfly network is allowed if it produces identical results.

Test Plan:
- NBANK=16, swap=0, xor_src all pointing at cleared bits, lane l addr=l, data=0x10+l, mask all 1 → cycle T+1: o_sram_we=0xFFFF, bank l gets word 0, data 0x10+l; no conflict.
- Same row with i_xor_swap=1 → bank (l<<1|l>>3)&15 receives 0x10+l; o_sram_we=0xFFFF.
- i_commit=1, i_id=2, no hold → filled_dval pulses exactly at T+2 with o_filled_id=2.
- Row A, then row B offered while i_hold=1 for 3 cycles → A held with we=0; B not acked; after the hold A issues, then B issues the next cycle; ordering is preserved.
- Lanes 3 and 7 both mapping to bank 5 → bank 5 gets lane 3's data; o_conflict=1 and stays 1 through 10 clean rows; cleared only by reset.
- Async reset asserted mid-cycle with a committed row in S1 → outputs 0 immediately; no filled_dval after release.
